instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle RV32 CHERI core. It takes the core's `pc_out` and returns the instruction word for that PC from a variable-latency instruction memory. It holds a small prefetch buffer of sequential words and discards stale in-flight responses when the core redirects. It also flags misaligned fetch PCs.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [2:0]  FETCH_MISALIGN = 3'd5;
  localparam int unsigned DEF_BUF_DEPTH  = 2;
  localparam int unsigned DEF_MAX_OUTST  = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of prefetched {addr, data} words; flush wins over push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   entries [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    cnt;
  logic           do_push;
  logic           do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign head    = entries[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: prefetches sequential words, drops stale responses on redirect,
// and flags misaligned fetch PCs.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [2:0]  fault_cause,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  logic [OW-1:0] outst;
  logic [OW-1:0] drop;
  logic [31:0]   fetch_addr;
  logic [31:0]   resp_addr;
  logic [31:0]   expect_addr;
  logic [SW-1:0] in_use;
  logic          fault;
  logic          hit;
  logic          redirect;
  logic          grant;
  logic          push;

  fetch_entry_t  head;
  logic [CW-1:0] buf_count;
  logic          buf_full;
  logic          buf_empty;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{addr: resp_addr, data: mem_rdata}),
    .pop        (hit),
    .flush      (redirect),
    .head       (head),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  // The PC the core should present next if it is following the sequential stream.
  always_comb begin
    expect_addr = fetch_addr;
    if (!buf_empty)
      expect_addr = head.addr;
    else if (outst > drop)
      expect_addr = resp_addr;
  end

  assign fault    = rst && (pc_in[1:0] != 2'b00);
  assign hit      = rst && !fault && !buf_empty && (head.addr == pc_in);
  assign redirect = rst && !fault && (pc_in != expect_addr);

  // Buffered words plus live in-flight words must fit in the buffer.
  assign in_use   = SW'(buf_count) + SW'(outst) - SW'(drop);
  assign mem_req  = rst && !redirect && !fault && !buf_full &&
                    (in_use < SW'(BUF_DEPTH)) && (outst < OW'(MAX_OUTST));
  assign mem_addr = fetch_addr;
  assign grant    = mem_req && mem_gnt;
  assign push     = rst && mem_rvalid && !redirect && (drop == '0);

  assign instr       = hit ? head.data : NOP_INSTR;
  assign instr_valid = hit;
  assign fetch_fault = fault;
  assign fault_cause = fault ? FETCH_MISALIGN : 3'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      outst      <= '0;
      drop       <= '0;
      fetch_addr <= '0;
      resp_addr  <= '0;
    end else if (redirect) begin
      // No request goes out on a redirect; a coincident response is discarded.
      outst      <= outst - OW'(mem_rvalid);
      drop       <= outst - OW'(mem_rvalid);
      fetch_addr <= pc_in;
      resp_addr  <= pc_in;
    end else begin
      outst <= outst + OW'(grant) - OW'(mem_rvalid);
      if (mem_rvalid) begin
        if (drop != '0)
          drop <= drop - OW'(1);
        else
          resp_addr <= resp_addr + 32'd4;
      end
      if (grant) fetch_addr <= fetch_addr + 32'd4;
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    mem_rvalid |-> (outst != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic [2:0]  fault_cause;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  logic gnt_en = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] glog[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  assign mem_gnt = gnt_en;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Memory: grants sampled at negedge, answered in order `lat` cycles later.
  initial begin
    logic        s_rst;
    logic        s_gnt;
    logic [31:0] s_addr;
    int          mcyc;
    pend_t       p;
    mcyc       = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_gnt  = mem_req & mem_gnt;
      s_addr = mem_addr;
      @(posedge clk);
      #1;
      mcyc++;
      if (!s_rst) begin
        pend_q.delete();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end else begin
        if (s_gnt) begin
          pend_q.push_back('{addr: s_addr, due: 32'(mcyc - 1 + lat)});
          glog.push_back(s_addr);
        end
        if (pend_q.size() > 0 && pend_q[0].due <= 32'(mcyc)) begin
          p          = pend_q.pop_front();
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(p.addr);
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = 32'h0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    pc_in = 32'h0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Core model: holds pc until instr_valid, then steps by 4.
  task automatic run_seq(input logic [31:0] start, input int n, input int budget,
                         input string tag);
    int   got = 0;
    int   cyc = 0;
    logic adv;
    pc_in = start;
    exp_q.push_back(mem_word(start));
    while (got < n && cyc < budget) begin
      #1;
      adv = instr_valid;
      if (instr_valid) begin
        chk(tag, instr, exp_q.pop_front());
        got++;
      end
      tick();
      cyc++;
      if (adv) begin
        pc_in = pc_in + 32'd4;
        if (got < n) exp_q.push_back(mem_word(pc_in));
      end
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
    exp_q.delete();
  endtask

  initial begin
    int k;

    // Reset values, with a misaligned pc that must not fault during reset.
    rst   = 1'b0;
    pc_in = 32'h2;
    tick();
    #1;
    chk("rst_req",   mem_req,     0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr,       NOP_INSTR);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_cause", fault_cause, 0);
    pc_in = 32'h0;
    tick();
    rst = 1'b1;

    // 1-cycle memory: request, response, hit in cycles 1..3.
    exp_q.push_back(mem_word(32'h0));
    #1;
    chk("c1_req",   mem_req,     1);
    chk("c1_addr",  mem_addr,    32'h0);
    chk("c1_valid", instr_valid, 0);
    tick();
    #1;
    chk("c2_valid", instr_valid, 0);
    tick();
    #1;
    chk("c3_valid", instr_valid, 1);
    chk("c3_instr", instr, exp_q.pop_front());
    tick();
    run_seq(32'h4, 8, 60, "seq");

    // 3-cycle memory: redirect while 0x8 and 0xC are in flight.
    lat = 3;
    do_reset();
    run_seq(32'h0, 2, 40, "lat3");
    k = 0;
    while (pend_q.size() != 2 && k < 10) begin
      tick();
      k++;
    end
    chk("inflight_n",  32'(pend_q.size()), 2);
    chk("inflight_a0", pend_q[0].addr, 32'h8);
    chk("inflight_a1", pend_q[1].addr, 32'hC);
    pc_in = 32'h100;
    #1;
    chk("redir_req",   mem_req,     0);
    chk("redir_valid", instr_valid, 0);
    tick();
    run_seq(32'h100, 3, 40, "redir");

    // Redirect in the same cycle as a live response.
    k = 0;
    while (!mem_rvalid && k < 20) begin
      tick();
      k++;
    end
    chk("rv_seen", mem_rvalid, 1);
    pc_in = 32'h200;
    #1;
    chk("rv_redir_req", mem_req, 0);
    tick();
    run_seq(32'h200, 3, 40, "rvredir");

    // Misaligned fetch, then realign.
    pc_in = 32'h102;
    #1;
    chk("mis_fault", fetch_fault, 1);
    chk("mis_cause", fault_cause, 32'(FETCH_MISALIGN));
    chk("mis_instr", instr,       NOP_INSTR);
    chk("mis_valid", instr_valid, 0);
    chk("mis_req",   mem_req,     0);
    tick();
    #1;
    chk("mis_hold_fault", fetch_fault, 1);
    chk("mis_hold_req",   mem_req,     0);
    tick();
    pc_in = 32'h104;
    #1;
    chk("realign_fault", fetch_fault, 0);
    chk("realign_cause", fault_cause, 0);
    run_seq(32'h104, 3, 40, "resume");

    // Address wrap-around.
    glog.delete();
    run_seq(32'hFFFF_FFFC, 3, 40, "wrap");
    chk("wrap_g0", glog[0], 32'hFFFF_FFFC);
    chk("wrap_g1", glog[1], 32'h0000_0000);

    // Grant withheld: request must hold steady with no instruction delivered.
    lat    = 1;
    gnt_en = 1'b0;
    pc_in  = 32'h300;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req",   mem_req,     1);
      chk("bp_addr",  mem_addr,    32'h300);
      chk("bp_valid", instr_valid, 0);
      tick();
    end
    gnt_en = 1'b1;
    run_seq(32'h300, 4, 40, "bp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
